// File: rtl/axis_decimator_ctrl_if.sv
// AXI4-Stream beat bundle used on both sides of the decimator run controller.
interface axis_decimator_ctrl_if #(
    parameter int AXIS_TDATA_WIDTH = 32
);
    logic [AXIS_TDATA_WIDTH-1:0] tdata;
    logic                        tvalid;
    logic                        tready;

    modport master (output tdata, output tvalid, input tready);
    modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/axis_decimator_ctrl.sv
// Run controller for the AXIS decimator: latches the rate, flushes the decimator
// in reset, then passes a fixed-length (or continuous) run of beats to the consumer.
module axis_decimator_ctrl #(
    parameter int AXIS_TDATA_WIDTH = 32,
    parameter int CNTR_WIDTH       = 32,
    parameter int SMPL_WIDTH       = 32,
    parameter int FLUSH_CYCLES     = 4
) (
    input  logic                  aclk,
    input  logic                  areset,
    input  logic [CNTR_WIDTH-1:0] cfg_rate,
    input  logic [SMPL_WIDTH-1:0] cfg_total,
    input  logic                  start,
    input  logic                  abort,
    output logic [CNTR_WIDTH-1:0] dec_cfg_data,
    output logic                  dec_aresetn,
    output logic                  busy,
    output logic                  done,
    output logic                  sts_aborted,
    output logic [SMPL_WIDTH-1:0] sts_count,
    axis_decimator_ctrl_if.slave  s_axis,
    axis_decimator_ctrl_if.master m_axis
);
    localparam int FW = $clog2(FLUSH_CYCLES + 1);
    localparam logic [CNTR_WIDTH-1:0] RATE_MIN = CNTR_WIDTH'(1);

    typedef enum logic [1:0] {S_IDLE, S_FLUSH, S_RUN, S_DONE} state_t;

    state_t                state, state_nxt;
    logic [FW-1:0]         flush_cnt;
    logic [SMPL_WIDTH-1:0] total_q;
    logic                  run;
    logic                  hs;
    logic                  last_beat;

    assign run       = (state == S_RUN);
    assign hs        = run && s_axis.tvalid && m_axis.tready;
    // total_q == 0 means continuous; the count then wraps freely
    assign last_beat = hs && (total_q != '0) && (sts_count == total_q - SMPL_WIDTH'(1));

    always_comb begin
        state_nxt     = state;
        dec_aresetn   = 1'b0;
        busy          = 1'b0;
        done          = 1'b0;
        s_axis.tready = 1'b0;
        m_axis.tvalid = 1'b0;
        m_axis.tdata  = s_axis.tdata;
        case (state)
            S_IDLE: begin
                if (start && !abort) state_nxt = S_FLUSH;
            end
            S_FLUSH: begin
                busy = 1'b1;
                if (abort)                     state_nxt = S_DONE;
                else if (flush_cnt == FW'(1))  state_nxt = S_RUN;
            end
            S_RUN: begin
                busy          = 1'b1;
                dec_aresetn   = 1'b1;
                s_axis.tready = m_axis.tready;
                m_axis.tvalid = s_axis.tvalid;
                if (abort || last_beat) state_nxt = S_DONE;
            end
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state        <= S_IDLE;
            dec_cfg_data <= RATE_MIN;
            total_q      <= '0;
            flush_cnt    <= '0;
            sts_count    <= '0;
            sts_aborted  <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                S_IDLE: begin
                    if (start && !abort) begin
                        // the decimator never raises tready with a zero configuration
                        dec_cfg_data <= (cfg_rate == '0) ? RATE_MIN : cfg_rate;
                        total_q      <= cfg_total;
                        sts_count    <= '0;
                        sts_aborted  <= 1'b0;
                        flush_cnt    <= FW'(FLUSH_CYCLES);
                    end
                end
                S_FLUSH: begin
                    flush_cnt <= flush_cnt - FW'(1);
                    if (abort) sts_aborted <= 1'b1;
                end
                S_RUN: begin
                    if (hs)    sts_count   <= sts_count + SMPL_WIDTH'(1);
                    if (abort) sts_aborted <= 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_axis_decimator_ctrl.sv
// Scoreboard bench for axis_decimator_ctrl: random upstream words and consumer
// backpressure, expected beats queued per run and popped by a monitor.
module tb_axis_decimator_ctrl;
    localparam int FLUSH = 4;

    logic        aclk = 1'b0;
    logic        areset;
    logic [31:0] cfg_rate, cfg_total;
    logic        start, abort;
    logic [31:0] dec_cfg_data;
    logic        dec_aresetn, busy, done, sts_aborted;
    logic [31:0] sts_count;

    axis_decimator_ctrl_if #(.AXIS_TDATA_WIDTH(32)) s_if ();
    axis_decimator_ctrl_if #(.AXIS_TDATA_WIDTH(32)) m_if ();

    axis_decimator_ctrl #(
        .AXIS_TDATA_WIDTH(32), .CNTR_WIDTH(32), .SMPL_WIDTH(32), .FLUSH_CYCLES(FLUSH)
    ) dut (
        .aclk(aclk), .areset(areset), .cfg_rate(cfg_rate), .cfg_total(cfg_total),
        .start(start), .abort(abort), .dec_cfg_data(dec_cfg_data),
        .dec_aresetn(dec_aresetn), .busy(busy), .done(done),
        .sts_aborted(sts_aborted), .sts_count(sts_count),
        .s_axis(s_if), .m_axis(m_if)
    );

    always #5 aclk = ~aclk;

    int          n_tests = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          last_beat_cyc = 0;
    int          n_done = 0;
    int          exp_done = 0;
    int          load_req = 0;
    int          rdy_mode = 0;
    bit          src_en = 1'b0;
    bit          src_rand = 1'b0;
    logic [31:0] src_words[$];
    logic [31:0] exp_q[$];

    always @(posedge aclk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
        n_tests++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp_v, cyc);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #2;
    endtask

    // model: a run delivers the first n upstream words, in order
    task automatic load_words(input int n_words, input int n_exp);
        src_words.delete();
        for (int i = 0; i < n_words; i++) src_words.push_back($urandom);
        for (int i = 0; i < n_exp; i++) exp_q.push_back(src_words[i]);
        load_req++;
    endtask

    // upstream source and consumer ready driver
    initial begin : src
        int  idx;
        int  seen;
        int  ph;
        bit  hs;
        idx = 0; seen = 0; ph = 0;
        s_if.tvalid = 1'b0; s_if.tdata = '0; m_if.tready = 1'b0;
        forever begin
            @(negedge aclk);
            hs = s_if.tvalid && s_if.tready;
            @(posedge aclk);
            #1;
            if (seen != load_req) begin
                seen = load_req;
                idx  = 0;
            end else if (hs) begin
                idx++;
            end
            ph++;
            case (rdy_mode)
                0:       m_if.tready = 1'b1;
                1:       m_if.tready = (ph % 3 == 0);
                2:       m_if.tready = 1'($urandom_range(0, 1));
                default: m_if.tready = 1'b0;
            endcase
            if (src_en && idx < src_words.size() && (!src_rand || $urandom_range(0, 3) != 0)) begin
                s_if.tvalid = 1'b1;
                s_if.tdata  = src_words[idx];
            end else begin
                s_if.tvalid = 1'b0;
                s_if.tdata  = $urandom;
            end
        end
    end

    // monitor: gating / pass-through and scoreboard pops
    initial begin : mon
        forever begin
            @(negedge aclk);
            if (done) n_done++;
            if (!dec_aresetn) begin
                check("gate_s_tready", s_if.tready, 0);
                check("gate_m_tvalid", m_if.tvalid, 0);
            end else begin
                check("mirror_tready", s_if.tready, m_if.tready);
                check("mirror_tvalid", m_if.tvalid, s_if.tvalid);
            end
            if (m_if.tvalid && m_if.tready) begin
                last_beat_cyc = cyc;
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL extra_beat: got 0x%0h, expected no beat (cycle %0d)", m_if.tdata, cyc);
                end else begin
                    check("beat_data", m_if.tdata, exp_q.pop_front());
                end
            end
        end
    end

    task automatic do_run(input logic [31:0] rate, input logic [31:0] total,
                          input bit rv, input int rm, input bit busy_start);
        int          k;
        logic [31:0] exp_rate;
        exp_rate = (rate == 0) ? 32'd1 : rate;
        load_words(int'(total) + 4, int'(total));
        src_rand = rv; rdy_mode = rm; src_en = 1'b1;
        cfg_rate = rate; cfg_total = total; start = 1'b1;
        tick();
        start = 1'b0; cfg_rate = $urandom; cfg_total = $urandom;
        for (k = 1; k <= 20; k++) begin
            @(negedge aclk);
            if (k == 1) begin
                check("start_busy", busy, 1);
                check("start_cfg", dec_cfg_data, exp_rate);
            end
            if (busy_start && k == 2) begin start = 1'b1; cfg_total = 2; end
            if (busy_start && k == 3) start = 1'b0;
            if (dec_aresetn) break;
        end
        check("flush_len", k, FLUSH + 1);
        for (k = 0; k < 300; k++) begin
            @(negedge aclk);
            if (done) break;
        end
        check("done_timeout", (k < 300), 1);
        check("done_latency", cyc, last_beat_cyc + 1);
        check("done_busy", busy, 0);
        check("run_count", sts_count, total);
        check("run_aborted", sts_aborted, 0);
        check("run_cfg", dec_cfg_data, exp_rate);
        check("run_beats_left", exp_q.size(), 0);
        exp_done++;
        @(negedge aclk);
        check("done_one_cycle", done, 0);
        check("count_held", sts_count, total);
        src_en = 1'b0; rdy_mode = 0;
    endtask

    task automatic abort_run();
        int cnt;
        int k;
        load_words(40, 11);
        src_rand = 1'b0; rdy_mode = 0; src_en = 1'b1;
        cfg_rate = $urandom_range(1, 50); cfg_total = 0; start = 1'b1;
        tick();
        start = 1'b0;
        cnt = 0;
        for (k = 0; k < 100; k++) begin
            @(negedge aclk);
            if (m_if.tvalid && m_if.tready) cnt++;
            if (cnt == 10) break;
        end
        check("abort_pre_beats", cnt, 10);
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        for (k = 1; k <= 10; k++) begin
            @(negedge aclk);
            if (done) break;
        end
        check("abort_done_lat", k, 1);
        check("abort_count", sts_count, 11);
        check("abort_flag", sts_aborted, 1);
        check("abort_busy", busy, 0);
        check("abort_beats_left", exp_q.size(), 0);
        exp_done++;
        repeat (3) @(negedge aclk);
        check("abort_gated", m_if.tvalid, 0);
        check("abort_flag_held", sts_aborted, 1);
        src_en = 1'b0;
    endtask

    task automatic flush_abort();
        int got;
        bit rose;
        src_en = 1'b0;
        cfg_rate = 4; cfg_total = 3; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        got = 0; rose = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge aclk);
            if (dec_aresetn) rose = 1'b1;
            if (done && got == 0) got = k;
        end
        check("fabort_done_lat", got, 1);
        check("fabort_no_release", rose, 0);
        check("fabort_count", sts_count, 0);
        check("fabort_flag", sts_aborted, 1);
        check("fabort_busy", busy, 0);
        exp_done++;
    endtask

    task automatic idle_start_abort();
        bit seen;
        cfg_total = 2; start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        seen = 1'b0;
        repeat (6) begin
            @(negedge aclk);
            if (busy || done || dec_aresetn) seen = 1'b1;
        end
        check("idle_start_abort", seen, 0);
        check("idle_flag_kept", sts_aborted, 1);
    endtask

    task automatic reset_run();
        int cnt;
        bit seen;
        load_words(20, 3);
        src_rand = 1'b0; rdy_mode = 0; src_en = 1'b1;
        cfg_rate = 6; cfg_total = 8; start = 1'b1;
        tick();
        start = 1'b0;
        cnt = 0;
        for (int k = 0; k < 100 && cnt < 3; k++) begin
            @(negedge aclk);
            if (m_if.tvalid && m_if.tready) cnt++;
        end
        check("rst_pre_beats", cnt, 3);
        rdy_mode = 3;
        tick();
        areset = 1'b1;
        tick();
        areset = 1'b0;
        @(negedge aclk);
        check("rst_count", sts_count, 0);
        check("rst_busy", busy, 0);
        check("rst_aresetn", dec_aresetn, 0);
        check("rst_done", done, 0);
        check("rst_cfg", dec_cfg_data, 1);
        check("rst_aborted", sts_aborted, 0);
        check("rst_beats_left", exp_q.size(), 0);
        seen = 1'b0;
        repeat (4) begin
            @(negedge aclk);
            if (done || busy) seen = 1'b1;
        end
        check("rst_quiet", seen, 0);
        src_en = 1'b0; rdy_mode = 0;
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1);
    end

    initial begin : main
        areset = 1'b1; start = 1'b0; abort = 1'b0; cfg_rate = '0; cfg_total = '0;
        repeat (3) tick();
        @(negedge aclk);
        check("reset_cfg", dec_cfg_data, 1);
        check("reset_aresetn", dec_aresetn, 0);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_aborted", sts_aborted, 0);
        check("reset_count", sts_count, 0);
        tick();
        areset = 1'b0;
        tick();

        do_run(32'd3, 32'd5, 1'b0, 0, 1'b0);
        do_run(32'd0, 32'd2, 1'b0, 0, 1'b0);
        do_run(32'd5, 32'd4, 1'b1, 1, 1'b0);
        do_run(32'd9, 32'd6, 1'b0, 2, 1'b1);
        abort_run();
        flush_abort();
        idle_start_abort();
        reset_run();
        for (int i = 0; i < 6; i++)
            do_run(32'($urandom_range(0, 20)), 32'($urandom_range(1, 8)), 1'b1, 2, 1'b0);

        repeat (3) tick();
        check("done_pulses", n_done, exp_done);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/axis_decimator_ctrl.md
# axis_decimator_ctrl

Run controller for the AXI4-Stream decimator in the acquisition chain. On a start request it latches a decimation setting, holds the decimator in reset while the setting settles, then releases it. It passes the decimated stream to the consumer and stops after a programmed number of output samples, or on abort. Software reconfigures the rate or takes fixed-length captures through this block, never by writing the decimator configuration directly.

## Interface
- AXIS_TDATA_WIDTH, 32, stream data width
- CNTR_WIDTH, 32, decimator configuration width
- SMPL_WIDTH, 32, sample-count width
- FLUSH_CYCLES, 4, cycles the decimator is held in reset before release (≥1)

- aclk  in  1  clock
- areset  in  1  synchronous, active-high reset
- cfg_rate  in  CNTR_WIDTH  requested decimator configuration; decimation factor = value+1
- cfg_total  in  SMPL_WIDTH  output samples per run; 0 = continuous
- start  in  1  run request, sampled each cycle
- abort  in  1  stop request, sampled each cycle
- dec_cfg_data  out  CNTR_WIDTH  configuration to the decimator
- dec_aresetn  out  1  active-low reset to the decimator
- busy  out  1  high in FLUSH and RUN
- done  out  1  one-cycle pulse at the end of a run
- sts_aborted  out  1  last run ended by abort; held until next start
- sts_count  out  SMPL_WIDTH  beats transferred in current or last run
- s_axis_tready  out  1  to decimator output
- s_axis_tdata  in  AXIS_TDATA_WIDTH  from decimator output
- s_axis_tvalid  in  1  from decimator output
- m_axis_tready  in  1  from consumer
- m_axis_tdata  out  AXIS_TDATA_WIDTH  to consumer
- m_axis_tvalid  out  1  to consumer

## Operation
- States: IDLE, FLUSH, RUN, DONE. Encoding is free.
- Reset values: state IDLE, dec_cfg_data 1, dec_aresetn 0, busy 0, done 0, sts_aborted 0, sts_count 0, s_axis_tready 0, m_axis_tvalid 0.
- IDLE behaviour:
  - dec_aresetn=0 and the stream is gated (s_axis_tready=0, m_axis_tvalid=0).
  - start=1 and abort=0: latch dec_cfg_data = (cfg_rate==0 ? 1 : cfg_rate), latch cfg_total, clear sts_count and sts_aborted, load the flush counter with FLUSH_CYCLES, go to FLUSH.
  - Clamping rationale: the decimator never asserts tready with configuration 0.
  - start and abort together in IDLE: start is ignored.
- FLUSH behaviour:
  - dec_aresetn=0 and the stream is gated.
  - The flush counter decrements each cycle. When it reaches 1, go to RUN.
  - abort: go to DONE.
- RUN behaviour:
  - dec_aresetn=1.
  - Combinational pass-through: m_axis_tdata = s_axis_tdata, m_axis_tvalid = s_axis_tvalid, s_axis_tready = m_axis_tready.
  - sts_count increments on every handshake (m_axis_tvalid & m_axis_tready).
  - cfg_total≠0 and a handshake occurs with sts_count == cfg_total−1: go to DONE. The stream is gated from the next cycle, so exactly cfg_total beats pass.
  - cfg_total==0: run until abort. sts_count wraps modulo 2^SMPL_WIDTH.
  - abort in RUN: go to DONE and set sts_aborted. A beat handshaking in the same cycle is counted and delivered.
- DONE behaviour:
  - Lasts exactly one cycle with done=1, dec_aresetn=0 and the stream gated, then goes to IDLE.
- Input sampling and retention:
  - start while busy or in DONE is ignored.
  - cfg_rate and cfg_total are sampled only at start. Changing them mid-run has no effect.
  - sts_count holds its final value until the next accepted start.
- areset in any state: return to reset values on the next edge, including mid-RUN. The in-flight beat is dropped.

## Timing
- start sampled at edge N: busy=1 and dec_cfg_data valid from cycle N+1.
- dec_aresetn stays 0 through cycles N+1 .. N+FLUSH_CYCLES and rises at cycle N+FLUSH_CYCLES+1 (RUN entry).
- The last counted handshake in cycle K gives done=1 in cycle K+1 and busy=0 from cycle K+1.
- abort sampled at edge A in FLUSH or RUN: done=1 in cycle A+1.
- Gating and pass-through are purely combinational in RUN. No added latency, no buffering.

## Test plan
- Capture run:
  - Stimulus: cfg_rate=3, cfg_total=5, FLUSH_CYCLES=4, start pulse; upstream tvalid constant; m_axis_tready=1.
  - Response: dec_aresetn rises 5 cycles after start; exactly 5 beats on m_axis; done one cycle after the 5th beat; sts_count=5; dec_cfg_data=3.
- Rate clamp:
  - Stimulus: cfg_rate=0, cfg_total=2.
  - Response: dec_cfg_data=1 and the run completes with 2 beats.
- Consumer backpressure:
  - Stimulus: cfg_total=4; m_axis_tready toggles 1,0,0,1,...
  - Response: s_axis_tready mirrors m_axis_tready; no beat lost or duplicated; sts_count=4.
- Continuous and abort:
  - Stimulus: cfg_total=0; abort after 10 beats, asserted in the same cycle as a handshake.
  - Response: sts_count=11, sts_aborted=1, done pulse; stream gated afterwards.
- start/abort corner cases:
  - start while busy: ignored, run length unchanged.
  - start and abort together in IDLE: stays IDLE.
  - abort during FLUSH: done pulse; dec_aresetn never rises; sts_count=0.
- Mid-run reset:
  - Stimulus: areset asserted in RUN after 3 beats.
  - Response: next cycle all outputs at reset values (dec_aresetn=0, sts_count=0, busy=0, no done pulse).
